// File: rtl/nest_token_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : nest_token_checker_if
// Description : Character stream and status bundle for nest_token_checker.
//               master = character source (drives in_valid/in, observes status)
//               slave  = checker (consumes characters, drives status)
// Signals     : in_valid  1      character qualifier
//               in        8      ASCII character
//               result    1      balanced and error-free
//               error     1      sticky error
//               overflow  1      sticky overflow
//               level     LVL_W  open block count
// Revision    : 1.0  initial release
// ============================================================================
interface nest_token_checker_if #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
);
    logic             in_valid;
    logic [7:0]       in;
    logic             result;
    logic             error;
    logic             overflow;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in,
        input  result, error, overflow, level
    );

    modport slave (
        input  in_valid, in,
        output result, error, overflow, level
    );
endinterface
`default_nettype wire

// File: rtl/nest_token_checker.sv
`default_nettype none
// ============================================================================
// Module      : nest_token_checker
// Description : Streaming keyword-nesting checker. Splits an ASCII stream into
//               words on space/LF, recognises begin/end (and fork/join when
//               FORK_JOIN_EN is defined) case-insensitively as whole words and
//               tracks nesting on a DEPTH-entry stack. Errors are sticky and
//               freeze the stack until reset.
// Ports       : clk    clock
//               reset  asynchronous, active-high reset
//               bus    nest_token_checker_if.slave (in_valid, in, result,
//                      error, overflow, level)
// Config      : FORK_JOIN_EN  enables fork/join and a 1-bit kind per entry
// Revision    : 1.0  initial release
// ============================================================================
module nest_token_checker #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    nest_token_checker_if.slave   bus
);

    localparam logic [LVL_W-1:0] c_DEPTH = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_ONE   = LVL_W'(1);
    localparam logic [7:0]       c_SPACE = 8'h20;
    localparam logic [7:0]       c_LF    = 8'h0A;

    typedef enum logic [4:0] {
        S_IDLE, S_PEND,
        S_B1, S_B2, S_B3, S_B4, S_B5,
        S_E1, S_E2, S_E3
`ifdef FORK_JOIN_EN
        , S_F1, S_F2, S_F3, S_F4,
        S_J1, S_J2, S_J3, S_J4
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LVL_W-1:0] r_level;
    logic             r_error;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_top_mismatch;
    logic             w_is_delim;
    logic [7:0]       w_ch;

    // Delimiters are checked on the raw byte; OR-ing 0x20 only folds
    // upper-case letters onto lower-case, so no other byte can alias a letter.
    assign w_is_delim = (bus.in == c_SPACE) || (bus.in == c_LF);
    assign w_ch       = bus.in | 8'h20;

`ifdef FORK_JOIN_EN
    // Kind per entry: 0 = begin, 1 = fork. Sized to the full index range so
    // level can index it directly; entries at or above DEPTH are never used.
    localparam int c_STK_N = 1 << LVL_W;
    logic [c_STK_N-1:0] r_stack;
    logic               w_kind;
`endif

    // Word recogniser: next state plus commit decode on the delimiter.
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_pop  = 1'b0;
`ifdef FORK_JOIN_EN
        w_kind = 1'b0;
`endif
        if (w_is_delim) begin
            w_next = S_IDLE;
            case (r_state)
                S_B5: w_push = 1'b1;
                S_E3: w_pop  = 1'b1;
`ifdef FORK_JOIN_EN
                S_F4: begin w_push = 1'b1; w_kind = 1'b1; end
                S_J4: begin w_pop  = 1'b1; w_kind = 1'b1; end
`endif
                default: ;
            endcase
        end else begin
            w_next = S_PEND;
            case (r_state)
                S_IDLE: begin
                    if      (w_ch == "b") w_next = S_B1;
                    else if (w_ch == "e") w_next = S_E1;
`ifdef FORK_JOIN_EN
                    else if (w_ch == "f") w_next = S_F1;
                    else if (w_ch == "j") w_next = S_J1;
`endif
                end
                S_B1: if (w_ch == "e") w_next = S_B2;
                S_B2: if (w_ch == "g") w_next = S_B3;
                S_B3: if (w_ch == "i") w_next = S_B4;
                S_B4: if (w_ch == "n") w_next = S_B5;
                S_E1: if (w_ch == "n") w_next = S_E2;
                S_E2: if (w_ch == "d") w_next = S_E3;
`ifdef FORK_JOIN_EN
                S_F1: if (w_ch == "o") w_next = S_F2;
                S_F2: if (w_ch == "r") w_next = S_F3;
                S_F3: if (w_ch == "k") w_next = S_F4;
                S_J1: if (w_ch == "o") w_next = S_J2;
                S_J2: if (w_ch == "i") w_next = S_J3;
                S_J3: if (w_ch == "n") w_next = S_J4;
`endif
                default: ;  // completed keywords and PEND fall into PEND
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (bus.in_valid) begin
            r_state <= w_next;
        end
    end

`ifdef FORK_JOIN_EN
    // At level 0 the index wraps, but the pop is rejected on level anyway.
    assign w_top_mismatch = (r_stack[r_level - c_ONE] != w_kind);
`else
    assign w_top_mismatch = 1'b0;
`endif

    // Stack and flags; once an error is flagged everything holds until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level    <= '0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
`ifdef FORK_JOIN_EN
            r_stack    <= '0;
`endif
        end else if (bus.in_valid && !r_error) begin
            if (w_push) begin
                if (r_level == c_DEPTH) begin
                    r_error    <= 1'b1;
                    r_overflow <= 1'b1;
                end else begin
`ifdef FORK_JOIN_EN
                    r_stack[r_level] <= w_kind;
`endif
                    r_level <= r_level + c_ONE;
                end
            end else if (w_pop) begin
                if ((r_level == '0) || w_top_mismatch) begin
                    r_error <= 1'b1;
                end else begin
                    r_level <= r_level - c_ONE;
                end
            end
        end
    end

    assign bus.level    = r_level;
    assign bus.error    = r_error;
    assign bus.overflow = r_overflow;
    assign bus.result   = (r_level == '0) && !r_error;

endmodule
`default_nettype wire

// File: tb/tb_nest_token_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nest_token_checker
// Description : Self-checking bench for nest_token_checker. A word-level
//               reference model (word buffer + kind queue) runs alongside the
//               DUT; every cycle the DUT status is compared against it.
//               Directed scenarios pin both DUT and model to literal values,
//               then random token streams with stalls, case flips and resets.
// Config      : FORK_JOIN_EN selects fork/join expectations
// Revision    : 1.0  initial release
// ============================================================================
module tb_nest_token_checker;

    localparam int DEPTH = 3;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    nest_token_checker_if #(.DEPTH(DEPTH), .LVL_W(LVL_W)) bus ();

    nest_token_checker #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: collect a word, interpret it when a delimiter lands.
    // ------------------------------------------------------------------
    logic [7:0] wq[$];
    bit         kst[$];        // open blocks, 0 = begin, 1 = fork
    bit         m_err = 1'b0;
    bit         m_ovf = 1'b0;

    function automatic logic [7:0] lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
        return c;
    endfunction

    function automatic bit is_kw(input string kw);
        if (wq.size() != kw.len()) return 1'b0;
        for (int i = 0; i < kw.len(); i++)
            if (wq[i] != kw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_push(input bit k);
        if (kst.size() == DEPTH) begin
            m_err = 1'b1;
            m_ovf = 1'b1;
        end else begin
            kst.push_back(k);
        end
    endfunction

    function automatic void m_pop(input bit k);
        if (kst.size() == 0) begin
            m_err = 1'b1;
        end else begin
`ifdef FORK_JOIN_EN
            if (kst[kst.size()-1] != k) m_err = 1'b1;
            else void'(kst.pop_back());
`else
            if (k) m_err = 1'b1;   // unreachable: no fork kind without the feature
            else void'(kst.pop_back());
`endif
        end
    endfunction

    function automatic void m_commit();
        if (m_err) return;
        if      (is_kw("begin")) m_push(1'b0);
        else if (is_kw("end"))   m_pop(1'b0);
`ifdef FORK_JOIN_EN
        else if (is_kw("fork"))  m_push(1'b1);
        else if (is_kw("join"))  m_pop(1'b1);
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wq.delete();
            kst.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
        end else if (bus.in_valid) begin
            if (bus.in == 8'h20 || bus.in == 8'h0A) begin
                m_commit();
                wq.delete();
            end else begin
                wq.push_back(lower(bus.in));
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("cyc_level",    int'(bus.level),    kst.size());
        check("cyc_error",    int'(bus.error),    int'(m_err));
        check("cyc_overflow", int'(bus.overflow), int'(m_ovf));
        check("cyc_result",   int'(bus.result),   int'(kst.size() == 0 && !m_err));
    end

    task automatic pin(input string name, input int lvl, input int err, input int ovf, input int res);
        check({name, "_lvl"},       int'(bus.level),    lvl);
        check({name, "_err"},       int'(bus.error),    err);
        check({name, "_ovf"},       int'(bus.overflow), ovf);
        check({name, "_res"},       int'(bus.result),   res);
        check({name, "_model_lvl"}, kst.size(),         lvl);
        check({name, "_model_err"}, int'(m_err),        err);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (all return #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            bus.in = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_char(input logic [7:0] c, input bit stall);
        while (stall && $urandom_range(0, 3) == 0) idle(1);
        bus.in_valid = 1'b1;
        bus.in       = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in       = 8'($urandom);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    string toks[16] = '{"begin", "end", "BEGIN", "End", "fork", "join", "FoRk",
                        "JOIN", "beginx", "xend", "be", "begi", "en", "endd",
                        "zz", "q"};

    initial begin
        bus.in_valid = 1'b0;
        bus.in       = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pin("reset", 0, 0, 0, 1);

        // 1: simple pair
        send_str("begin ");
        pin("t1_open", 1, 0, 0, 0);
        send_str("end ");
        pin("t1_close", 0, 0, 0, 1);

        // 2: mixed case and a non-keyword
        do_reset();
        send_str("BeGiN beginx");
        pin("t2_nodelim", 1, 0, 0, 0);
        send_str(" end ");
        pin("t2_end", 0, 0, 0, 1);

        // 3: unmatched closer freezes state
        do_reset();
        send_str("end ");
        pin("t3_err", 0, 1, 0, 0);
        send_str("begin ");
        pin("t3_frozen", 0, 1, 0, 0);

        // 4: overflow at DEPTH
        do_reset();
        send_str("begin\nbegin  begin ");
        pin("t4_full", 3, 0, 0, 0);
        send_str("begin ");
        pin("t4_ovf", 3, 1, 1, 0);

        // 5: fork/join
        do_reset();
        send_str("begin fork end ");
`ifdef FORK_JOIN_EN
        pin("t5_mismatch", 2, 1, 0, 0);
`else
        pin("t5_plainword", 0, 0, 0, 1);
`endif
        do_reset();
        send_str("fork join ");
        pin("t5_fj", 0, 0, 0, 1);

        // 6: stall mid-word, then reset mid-word
        do_reset();
        send_str("begi");
        idle(5);
        send_str("n ");
        pin("t6_stall", 1, 0, 0, 0);
        send_str("be");
        do_reset();
        pin("t6_reset", 0, 0, 0, 1);
        send_str("end ");
        pin("t6_after", 0, 1, 0, 0);

        // Random token streams
        do_reset();
        for (int t = 0; t < 2500; t++) begin
            string w;
            w = toks[$urandom_range(0, 15)];
            for (int i = 0; i < w.len(); i++) begin
                logic [7:0] c;
                c = w[i];
                if ($urandom_range(0, 2) == 0) c = c ^ 8'h20;
                send_char(c, 1'b1);
            end
            send_char(($urandom_range(0, 1) == 0) ? 8'h20 : 8'h0A, 1'b1);
            if ($urandom_range(0, 4) == 0) send_char(8'h20, 1'b1);
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0)
                do_reset();
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
